mem_stage: RTL



---
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// This is the memory-access stage of the core_lapido pipeline. It sits
// between the EX/MEM latch and the write-back selector.
//
// Loads and stores go to the data memory over a registered req/ack
// handshake. While an access is outstanding, upstream is held by a
// combinational stall. A watchdog counter bounds each access. When it
// expires, the instruction is retired with register write-back suppressed,
// and bus_error pulses for one cycle.
//
// The stage also owns the MEM/WB pipeline register.
//
// Parameters
//   PC_WIDTH   width of next_pc
//   MAX_WAIT   ACCESS cycles without ack before timeout (1..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, flush            EX/MEM holds an instruction / squash it (IDLE only)
//   mem_read, mem_write        load / store (store wins when both are set)
//   wb_res_mux .. imm          write-back fields passed to MEM/WB
//   store_data                 store write data
//   dmem_req/we/addr/wdata     registered memory request
//   dmem_ack, dmem_rdata       memory completion and load data
//   stall                      hold request to upstream stages
//   out_*                      MEM/WB register
//   bus_error                  one-cycle pulse on access timeout
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int PC_WIDTH = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                flush,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          wb_res_mux,
    input  logic                reg_write_enable,
    input  logic [4:0]          reg_dst,
    input  logic [PC_WIDTH-1:0] next_pc,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         imm,
    input  logic [31:0]         store_data,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                stall,
    output logic                out_valid,
    output logic [1:0]          out_wb_res_mux,
    output logic                out_reg_write_enable,
    output logic [4:0]          out_reg_dst,
    output logic [PC_WIDTH-1:0] out_next_pc,
    output logic [31:0]         out_alu_res,
    output logic [31:0]         out_imm,
    output logic [31:0]         out_mem_data,
    output logic                bus_error
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_r;
    logic [7:0]            wait_cnt_r;

    // Instruction fields held for the duration of an access.
    logic [1:0]            cap_wb_res_mux_r;
    logic                  cap_reg_write_enable_r;
    logic [4:0]            cap_reg_dst_r;
    logic [PC_WIDTH-1:0]   cap_next_pc_r;
    logic [31:0]           cap_alu_res_r;
    logic [31:0]           cap_imm_r;

    logic                  accept_s;
    logic                  mem_op_s;
    logic                  expired_s;
    logic                  stall_s;

    assign accept_s  = in_valid & ~flush;
    assign mem_op_s  = mem_read | mem_write;
    assign expired_s = (wait_cnt_r == MAX_WAIT_C);

    // Upstream hold. Stall drops in the cycle the access ends (ack or
    // timeout), so upstream advances on that same edge.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = accept_s & mem_op_s;
            ACCESS:  stall_s = ~dmem_ack & ~expired_s;
            default: stall_s = 1'b0;
        endcase
    end

    assign stall = stall_s;

    // FSM: state, watchdog, memory request and MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r                <= IDLE;
            wait_cnt_r             <= 8'd0;
            cap_wb_res_mux_r       <= 2'd0;
            cap_reg_write_enable_r <= 1'b0;
            cap_reg_dst_r          <= 5'd0;
            cap_next_pc_r          <= '0;
            cap_alu_res_r          <= 32'd0;
            cap_imm_r              <= 32'd0;
            dmem_req               <= 1'b0;
            dmem_we                <= 1'b0;
            dmem_addr              <= 32'd0;
            dmem_wdata             <= 32'd0;
            out_valid              <= 1'b0;
            out_wb_res_mux         <= 2'd0;
            out_reg_write_enable   <= 1'b0;
            out_reg_dst            <= 5'd0;
            out_next_pc            <= '0;
            out_alu_res            <= 32'd0;
            out_imm                <= 32'd0;
            out_mem_data           <= 32'd0;
            bus_error              <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && mem_op_s) begin
                        state_r                <= ACCESS;
                        wait_cnt_r             <= 8'd0;
                        cap_wb_res_mux_r       <= wb_res_mux;
                        cap_reg_write_enable_r <= reg_write_enable;
                        cap_reg_dst_r          <= reg_dst;
                        cap_next_pc_r          <= next_pc;
                        cap_alu_res_r          <= alu_res;
                        cap_imm_r              <= imm;
                        dmem_req               <= 1'b1;
                        dmem_we                <= mem_write;
                        dmem_addr              <= alu_res;
                        dmem_wdata             <= store_data;
                        out_valid              <= 1'b0;
                        out_reg_write_enable   <= 1'b0;
                    end else if (accept_s) begin
                        out_valid            <= 1'b1;
                        out_wb_res_mux       <= wb_res_mux;
                        out_reg_write_enable <= reg_write_enable;
                        out_reg_dst          <= reg_dst;
                        out_next_pc          <= next_pc;
                        out_alu_res          <= alu_res;
                        out_imm              <= imm;
                        out_mem_data         <= 32'd0;
                    end else begin
                        // Bubble: only the qualifiers change, data fields hold.
                        out_valid            <= 1'b0;
                        out_reg_write_enable <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack || expired_s) begin
                        state_r        <= IDLE;
                        wait_cnt_r     <= 8'd0;
                        dmem_req       <= 1'b0;
                        out_valid      <= 1'b1;
                        out_wb_res_mux <= cap_wb_res_mux_r;
                        out_reg_dst    <= cap_reg_dst_r;
                        out_next_pc    <= cap_next_pc_r;
                        out_alu_res    <= cap_alu_res_r;
                        out_imm        <= cap_imm_r;
                        if (dmem_ack) begin
                            out_reg_write_enable <= cap_reg_write_enable_r;
                            out_mem_data         <= dmem_we ? 32'd0 : dmem_rdata;
                        end else begin
                            // Timeout: retire without write-back.
                            out_reg_write_enable <= 1'b0;
                            out_mem_data         <= 32'd0;
                            bus_error            <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r           <= wait_cnt_r + 8'd1;
                        out_valid            <= 1'b0;
                        out_reg_write_enable <= 1'b0;
                    end
                end
                default: begin
                    state_r              <= IDLE;
                    wait_cnt_r           <= 8'd0;
                    dmem_req             <= 1'b0;
                    out_valid            <= 1'b0;
                    out_reg_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
